instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction source for the control decoder: fetches 32-bit words from instruction memory over a req/ack
//  handshake, holds instrWord stable for decode/execute, then advances the PC.
//  Next PC is sequential (+4) or the branch target, using the held word's 16-bit immediate when the
//  datapath reports a taken branch (Branch & zero).
//  Sits between imem and the ControlPath/datapath pair.
// PARAMETERS
//  ADDR_W    32            PC / imem address width
//  RESET_PC  {ADDR_W{1'b0}} PC after reset; bits [1:0] must be 2'b00
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst            in   1       synchronous, active-high reset
//  imem_req       out  1       fetch request, held until imem_ack
//  imem_addr      out  ADDR_W  fetch address (= pc), stable while imem_req=1
//  imem_ack       in   1       imem_rdata valid this cycle; honoured only while imem_req=1
//  imem_rdata     in   32      fetched instruction word
//  instrWord      out  32      held instruction, drives decoder instrWord
//  instr_valid    out  1       instrWord holds a fetched, unconsumed instruction
//  instr_ready    in   1       datapath consumes instrWord this cycle
//  branch_taken   in   1       held instruction is a taken branch; sampled only on consume
//  pc             out  ADDR_W  address of the held/requested instruction
//  retired_count  out  32      count of consumed instructions
// BEHAVIOUR
//  Reset (rst=1 at edge): state=BOOT, pc=RESET_PC, imem_req=0, instr_valid=0, instrWord=32'h0,
//   retired_count=0. rst overrides all other inputs.
//  FSM, registered outputs:
//   BOOT: imem_req=0 -> REQ next cycle (one idle cycle after reset release).
//   REQ : imem_req=1, imem_addr=pc. On imem_ack=1: instrWord<=imem_rdata, instr_valid<=1,
//         imem_req<=0, ->HOLD. Without ack: stay, imem_req and imem_addr unchanged.
//   HOLD: instr_valid=1, instrWord stable. On instr_ready=1 (consume): instr_valid<=0,
//         retired_count<=retired_count+1, pc<=next_pc, ->REQ. Without ready: hold everything.
//  next_pc, modulo 2^ADDR_W:
//   branch_taken=0: pc+4
//   branch_taken=1: pc+4+({{(ADDR_W-18){instrWord[15]}},instrWord[15:0],2'b00})
//  pc[1:0] always 2'b00. Overflow wraps silently, e.g. 32'hFFFF_FFFC+4 = 0.
//  Latency: with ack in the first REQ cycle and ready in the first HOLD cycle, one instruction every
//   2 cycles. Each imem wait cycle adds 1 cycle; each ready-low cycle adds 1 cycle.
//  imem_ack in BOOT or HOLD is ignored. branch_taken and instr_ready are ignored outside HOLD.
//  retired_count wraps 32'hFFFF_FFFF->0.
//  Reset mid-operation: any outstanding request is abandoned. imem_req=0 the cycle after the rst edge.
//   imem must drop a request when imem_req falls. Refetch starts at RESET_PC after BOOT.
//  No combinational path from any input to any output.
// TESTING
//  1 Reset: rst=1 for 2 cycles -> all outputs at reset values. First cycle after release: imem_req=0.
//    Next cycle: imem_req=1, imem_addr=0.
//  2 Sequential: zero-wait ack, ready=1; imem[0]=32'h8C010004 (lw), imem[4]=32'hAC010008 (sw)
//    -> instrWord lw then sw, imem_addr 0,4,8, instr_valid every 2nd cycle, retired_count=2.
//  3 Wait states: ack delayed 3 cycles -> imem_req=1 with imem_addr=4 stable for 4 cycles;
//    instr_valid=0 throughout; word latched on the ack cycle.
//  4 Backpressure: instr_ready=0 for 5 cycles in HOLD -> instrWord, pc, instr_valid stable;
//    imem_req=0; retired_count unchanged.
//  5 Branch at pc=32'h10:
//    instrWord=32'h1000FFFF, branch_taken=1 -> next imem_addr=32'h10.
//    instrWord=32'h10000003, taken -> 32'h20.
//    Same word with branch_taken=0 -> 32'h14.
//  6 Boundaries: RESET_PC=32'hFFFF_FFFC -> second fetch at 32'h0.
//    rst asserted in REQ with ack pending -> imem_req=0 next cycle; late ack ignored;
//    refetch from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches one word over a req/ack handshake, holds it for decode,
// then advances pc to pc+4 or to the branch target.
//
//  state | meaning
//  BOOT  | idle cycle after reset, no request
//  REQ   | request outstanding at imem_addr = pc, waiting for imem_ack
//  HOLD  | instrWord valid, waiting for instr_ready to consume it
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instrWord,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_taken,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       retired_count
);

  typedef enum logic [1:0] {BOOT, REQ, HOLD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] next_pc;

  // Branch offset is the held word's immediate in words, sign-extended, relative to pc+4.
  assign seq_pc    = pc + {{(ADDR_W-3){1'b0}}, 3'd4};
  assign br_off    = {{(ADDR_W-18){instrWord[15]}}, instrWord[15:0], 2'b00};
  assign next_pc   = branch_taken ? (seq_pc + br_off) : seq_pc;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      imem_req      <= 1'b0;
      instr_valid   <= 1'b0;
      instrWord     <= 32'h0;
      retired_count <= 32'h0;
    end else begin
      case (state)
        BOOT: begin
          imem_req <= 1'b1;
          state    <= REQ;
        end
        REQ: begin
          if (imem_ack) begin
            instrWord   <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid   <= 1'b0;
            retired_count <= retired_count + 32'd1;
            pc            <= next_pc;
            imem_req      <= 1'b1;
            state         <= REQ;
          end
        end
        default: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          state       <= BOOT;
        end
      endcase
    end
  end

endmodule
